// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment scanner: one shared segment bus, one-hot digit select,
// a blank guard before every digit slot and a per-frame strobe. Optional feature macro: LEADING_ZERO_BLANK_EN.
module seg_scan_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [8*NUM_DIGITS-1:0] digit_segs,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SNAP = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [7:0]            r_seg_out;
    logic [NUM_DIGITS-1:0] r_dig_sel;
    logic                  r_frame_done;

    logic [CW-1:0]         w_nxt_cnt;
    logic [IW-1:0]         w_nxt_idx;
    phase_t                w_nxt_phase;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic                  w_suppress;
    logic [7:0]            w_digits [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_unpack
        assign w_digits[g] = digit_segs[8*g +: 8];
    end

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] ZERO_GLYPH = 8'b1111_1100;

    logic [NUM_DIGITS-1:0] w_is_zero;
    logic [NUM_DIGITS-1:0] w_lead_zero;

    // w_lead_zero[i]: digit i and every digit above it show the zero glyph
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
        assign w_is_zero[g]   = (w_digits[g] == ZERO_GLYPH);
        assign w_lead_zero[g] = &w_is_zero[NUM_DIGITS-1:g];
    end

    assign w_suppress = (w_nxt_idx != '0) && w_lead_zero[w_nxt_idx];
`else
    assign w_suppress = 1'b0;
`endif

    always_comb begin
        w_nxt_cnt = '0;
        w_nxt_idx = '0;
        if (enable) begin
            if (r_cnt == CNT_LAST) begin
                w_nxt_idx = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                w_nxt_cnt = r_cnt + CW'(1);
                w_nxt_idx = r_idx;
            end
        end
    end

    assign w_nxt_phase = (w_nxt_cnt < CNT_SNAP) ? PH_BLANK : PH_SHOW;
    assign w_onehot    = NUM_DIGITS'(1) << w_nxt_idx;

    // NOTE: outputs are registered from the next-state values, so they line up
    // with (cnt, idx) in the same cycle instead of trailing it by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_seg_out    <= '0;
            r_dig_sel    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_nxt_cnt;
            r_idx        <= w_nxt_idx;
            r_frame_done <= enable && (w_nxt_cnt == CNT_LAST) && (w_nxt_idx == IDX_LAST);
            if (!enable || w_nxt_phase == PH_BLANK) begin
                r_seg_out <= '0;
                r_dig_sel <= '0;
            end else if (w_nxt_cnt == CNT_SNAP) begin
                r_seg_out <= w_suppress ? '0 : w_digits[w_nxt_idx];
                r_dig_sel <= w_suppress ? '0 : w_onehot;
            end
            // otherwise hold the snapshot for the rest of the slot
        end
    end

    assign seg_out    = r_seg_out;
    assign dig_sel    = r_dig_sel;
    assign frame_done = r_frame_done;

endmodule
